traffic_light_multi: RTL and testbench
======================================

Name: traffic_light_multi

Overview:
- Parametrised successor to the two-approach intersection controller: N_DIR approaches, round-robin service of latched car demand.
- Configurable min/max green, yellow and all-red intervals; green is extended while the served approach still has traffic.
- Sits between the board switch/sensor inputs and the LED/7-segment drivers; the seconds countdown output feeds the existing hex decoder.

Parameters:
- CNT_MAX, 50000000, clocks per 1-second tick (benches override to 5).
- N_DIR, 4, number of approaches (2..8).
- MIN_GREEN, 30, seconds of guaranteed green.
- MAX_GREEN, 60, seconds of green cap while others wait (>= MIN_GREEN).
- YELLOW_T, 3, yellow seconds (>= 1).
- ALLRED_T, 1, all-red clearance seconds (0 = phase skipped).
- CW, 8, countdown/elapsed width; must hold MAX_GREEN.

Ports:
- CLOCK_50  in  1  system clock.
- KEY  in  1  reset: synchronous, active-high.
- SW  in  N_DIR  car sensor per approach, level, already synchronised.
- LED  out  3*N_DIR  per approach i, bits [3i+2:3i] = {red,yellow,green}, one-hot: 001 green, 010 yellow, 100 red.
- ACTIVE  out  3  index of approach currently or last granted.
- CNT  out  CW  seconds remaining in current phase (see below).
- SEC_TICK  out  1  one-cycle pulse per second.

Behaviour:
- Prescaler counts 0..CNT_MAX-1; SEC_TICK=1 on the cycle the count equals CNT_MAX-1, then wraps to 0. All phase timing advances only on SEC_TICK cycles.
- Reset (KEY=1 at a clock edge): prescaler=0, state=GREEN, ACTIVE=0, elapsed=0, demand=0, CNT=MIN_GREEN, LED approach 0 = 001, all others 100, SEC_TICK=0. Reset mid-phase aborts immediately to this state; no yellow is shown.
- Demand: demand[i] set on any clock with SW[i]=1 and i != served approach (1-cycle latency). Cleared on the cycle approach i enters GREEN. SW of the served approach never latches.
- GREEN: elapsed increments on each tick, saturating at MAX_GREEN.
  - Exit to YELLOW on a tick when any demand bit is set AND either (elapsed >= MIN_GREEN and SW[ACTIVE]=0) or elapsed >= MAX_GREEN. Both conditions are evaluated with the post-increment elapsed value.
  - With no demand pending, green holds indefinitely.
  - On exit, next = first set demand bit scanning ACTIVE+1 upward, wrapping modulo N_DIR; next is registered.
  - CNT = MIN_GREEN-elapsed, floored at 0.
- YELLOW: served approach shows 010, others 100. Lasts YELLOW_T ticks, then goes to ALLRED, or straight to GREEN(next) if ALLRED_T=0. CNT counts down YELLOW_T..1.
- ALLRED: every approach shows 100 for ALLRED_T ticks, then GREEN(next). ACTIVE updates, elapsed=0, demand[next] clears. CNT counts down ALLRED_T..1.
- Invariant: at most one approach non-red on every cycle; LED fields are always one-hot.
- Simultaneous events: demand raised on the same tick as the exit decision is included in the scan. A demand bit cleared on grant and re-asserted by SW on the same cycle stays clear, because the granted approach does not latch.
- ACTIVE width is fixed at 3; upper bits are 0 when N_DIR < 8.

Test Plan (CNT_MAX=5, N_DIR=4, MIN_GREEN=4, MAX_GREEN=8, YELLOW_T=2, ALLRED_T=1):
1. Reset 3 cycles, SW=0, run 200 cycles -> LED=100_100_100_001, ACTIVE=0, CNT reaches 0 and holds; SEC_TICK pulses exactly every 5 cycles.
2. SW[2]=1 pulsed for 1 cycle at cycle 10 -> at tick 4 approach 0 goes yellow (010) for 2 ticks, then all-red for 1 tick, then approach 2 green (ACTIVE=2, LED[8:6]=001), demand[2] cleared.
3. From ACTIVE=0, SW[0] held high and SW[1] pulsed -> green extended past MIN_GREEN; yellow begins exactly at tick 8 (MAX_GREEN).
4. SW=4'b1111 held -> grant order 0,1,2,3,0; each green lasts 8 ticks; every cycle has at most one non-red approach.
5. KEY asserted for 1 cycle during YELLOW -> next cycle LED approach 0=001, all others 100, ACTIVE=0, CNT=4, demand=0.
6. Rebuild with ALLRED_T=0, repeat scenario 2 -> yellow is followed directly by green on approach 2 with no all-red cycle.

Source files
------------

// File: rtl/traffic_light_multi.sv
// N-approach traffic light controller: round-robin service of latched car demand,
// with min/max green, yellow and optional all-red clearance timed in seconds.
module traffic_light_multi #(
  parameter int CNT_MAX   = 50000000,
  parameter int N_DIR     = 4,
  parameter int MIN_GREEN = 30,
  parameter int MAX_GREEN = 60,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CW        = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY,
  input  logic [N_DIR-1:0]     SW,
  output logic [3*N_DIR-1:0]   LED,
  output logic [2:0]           ACTIVE,
  output logic [CW-1:0]        CNT,
  output logic                 SEC_TICK
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  localparam int PW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_MAX - 1);
  localparam logic [CW-1:0] LP_MIN     = CW'(MIN_GREEN);
  localparam logic [CW-1:0] LP_MAX     = CW'(MAX_GREEN);
  localparam logic [CW-1:0] LP_YELLOW  = CW'(YELLOW_T);
  localparam logic [CW-1:0] LP_ALLRED  = CW'(ALLRED_T);

  logic [PW-1:0]    r_presc;
  state_t           r_state;
  logic [2:0]       r_active;
  logic [2:0]       r_next;
  logic [CW-1:0]    r_elapsed;
  logic [CW-1:0]    r_phase;
  logic [N_DIR-1:0] r_demand;

  state_t           w_stateNext;
  logic [2:0]       w_activeNext;
  logic [2:0]       w_nextNext;
  logic [CW-1:0]    w_elapsedNext;
  logic [CW-1:0]    w_phaseNext;
  logic [N_DIR-1:0] w_demandNext;
  logic [PW-1:0]    w_prescNext;

  logic             w_tick;
  logic             w_grant;
  logic             w_swActive;
  logic [N_DIR-1:0] w_activeMask;
  logic [N_DIR-1:0] w_nextMask;
  logic [N_DIR-1:0] w_demandRaw;
  logic [CW-1:0]    w_elapsedInc;
  logic [2:0]       w_scanHigh;
  logic [2:0]       w_scanLow;
  logic             w_foundHigh;
  logic [2:0]       w_scanIdx;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_prescNext = w_tick ? '0 : r_presc + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      r_presc   <= '0;
      r_state   <= ST_GREEN;
      r_active  <= '0;
      r_next    <= '0;
      r_elapsed <= '0;
      r_phase   <= '0;
      r_demand  <= '0;
    end else begin
      r_presc   <= w_prescNext;
      r_state   <= w_stateNext;
      r_active  <= w_activeNext;
      r_next    <= w_nextNext;
      r_elapsed <= w_elapsedNext;
      r_phase   <= w_phaseNext;
      r_demand  <= w_demandNext;
    end
  end

  // Demand seen this cycle includes fresh sensor hits, so they join the exit scan.
  always_comb begin
    w_activeMask = '0;
    w_nextMask   = '0;
    w_swActive   = 1'b0;
    for (int i = 0; i < N_DIR; i++) begin
      if (r_active == 3'(i)) begin
        w_activeMask[i] = 1'b1;
        w_swActive      = SW[i];
      end
      if (r_next == 3'(i)) begin
        w_nextMask[i] = 1'b1;
      end
    end
    w_demandRaw  = r_demand | (SW & ~w_activeMask);
    w_elapsedInc = (r_elapsed >= LP_MAX) ? LP_MAX : r_elapsed + 1'b1;
  end

  // Round-robin: lowest demanding index above ACTIVE, else lowest index at or below it.
  always_comb begin
    w_scanHigh  = r_active;
    w_scanLow   = r_active;
    w_foundHigh = 1'b0;
    for (int i = N_DIR - 1; i >= 0; i--) begin
      if (w_demandRaw[i] && (3'(i) > r_active)) begin
        w_scanHigh  = 3'(i);
        w_foundHigh = 1'b1;
      end
      if (w_demandRaw[i] && (3'(i) <= r_active)) begin
        w_scanLow = 3'(i);
      end
    end
    w_scanIdx = w_foundHigh ? w_scanHigh : w_scanLow;
  end

  always_comb begin
    w_stateNext   = r_state;
    w_activeNext  = r_active;
    w_nextNext    = r_next;
    w_elapsedNext = r_elapsed;
    w_phaseNext   = r_phase;
    w_demandNext  = w_demandRaw;
    w_grant       = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_GREEN: begin
          w_elapsedNext = w_elapsedInc;
          if ((|w_demandRaw) &&
              (((w_elapsedInc >= LP_MIN) && !w_swActive) || (w_elapsedInc >= LP_MAX))) begin
            w_stateNext = ST_YELLOW;
            w_phaseNext = LP_YELLOW;
            w_nextNext  = w_scanIdx;
          end
        end
        ST_YELLOW: begin
          if (r_phase <= CW'(1)) begin
            if (ALLRED_T == 0) begin
              w_grant = 1'b1;
            end else begin
              w_stateNext = ST_ALLRED;
              w_phaseNext = LP_ALLRED;
            end
          end else begin
            w_phaseNext = r_phase - 1'b1;
          end
        end
        ST_ALLRED: begin
          if (r_phase <= CW'(1)) begin
            w_grant = 1'b1;
          end else begin
            w_phaseNext = r_phase - 1'b1;
          end
        end
        default: begin
          w_stateNext = ST_GREEN;
        end
      endcase
    end
    if (w_grant) begin
      w_stateNext   = ST_GREEN;
      w_activeNext  = r_next;
      w_elapsedNext = '0;
      w_demandNext  = w_demandRaw & ~w_nextMask;
    end
  end

  always_comb begin
    LED = '0;
    for (int i = 0; i < N_DIR; i++) begin
      if ((r_state != ST_ALLRED) && (r_active == 3'(i))) begin
        LED[3*i +: 3] = (r_state == ST_GREEN) ? 3'b001 : 3'b010;
      end else begin
        LED[3*i +: 3] = 3'b100;
      end
    end
    ACTIVE   = r_active;
    SEC_TICK = w_tick;
    if (r_state == ST_GREEN) begin
      CNT = (r_elapsed >= LP_MIN) ? '0 : LP_MIN - r_elapsed;
    end else begin
      CNT = r_phase;
    end
  end

endmodule

// File: tb/tb_traffic_light_multi.sv
// Bench for traffic_light_multi: two instances (all-red 1 and 0) checked every cycle
// against a reference model through a scoreboard, plus directed timing checks.
module tb_traffic_light_multi;

  localparam int CNT_MAX   = 5;
  localparam int N_DIR     = 4;
  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 8;
  localparam int YELLOW_T  = 2;
  localparam int CW        = 8;
  localparam logic [11:0] RST_LED = 12'b100_100_100_001;
  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

  typedef struct {
    logic [11:0] led;
    logic [2:0]  act;
    logic [7:0]  cnt;
    logic        tick;
  } exp_t;

  logic        CLOCK_50 = 1'b0;
  logic        KEY = 1'b1;
  logic [3:0]  SW = 4'b0;
  logic [11:0] ledA, ledB;
  logic [2:0]  actA, actB;
  logic [7:0]  cntA, cntB;
  logic        tickA, tickB;

  int compared = 0;
  int mismatched = 0;
  int k = 0;

  int mState[2];
  int mActive[2];
  int mNext[2];
  int mElapsed[2];
  int mPhase[2];
  int mPresc[2];
  logic [3:0] mDemand[2];
  int allredT[2] = '{1, 0};

  exp_t sbQ[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  traffic_light_multi #(.CNT_MAX(CNT_MAX), .N_DIR(N_DIR), .MIN_GREEN(MIN_GREEN),
    .MAX_GREEN(MAX_GREEN), .YELLOW_T(YELLOW_T), .ALLRED_T(1), .CW(CW)) dutA (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LED(ledA), .ACTIVE(actA),
    .CNT(cntA), .SEC_TICK(tickA));

  traffic_light_multi #(.CNT_MAX(CNT_MAX), .N_DIR(N_DIR), .MIN_GREEN(MIN_GREEN),
    .MAX_GREEN(MAX_GREEN), .YELLOW_T(YELLOW_T), .ALLRED_T(0), .CW(CW)) dutB (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LED(ledB), .ACTIVE(actB),
    .CNT(cntB), .SEC_TICK(tickB));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, k);
    end
  endtask

  function automatic int scanNext(input int a, input logic [3:0] d);
    logic [3:0] t;
    for (int s = 1; s <= N_DIR; s++) begin
      t = d >> ((a + s) % N_DIR);
      if (t[0]) return (a + s) % N_DIR;
    end
    return a;
  endfunction

  task automatic modelStep(input int m, input logic [3:0] sw, input logic key);
    bit tick;
    bit grant;
    logic [3:0] dem;
    logic [3:0] t;
    int e;
    if (key) begin
      mPresc[m] = 0; mState[m] = 0; mActive[m] = 0; mNext[m] = 0;
      mElapsed[m] = 0; mPhase[m] = 0; mDemand[m] = 4'b0;
      return;
    end
    grant = 0;
    tick = (mPresc[m] == CNT_MAX - 1);
    mPresc[m] = tick ? 0 : mPresc[m] + 1;
    dem = mDemand[m] | (sw & ~(4'b0001 << mActive[m]));
    t = sw >> mActive[m];
    if (tick) begin
      if (mState[m] == 0) begin
        e = (mElapsed[m] + 1 > MAX_GREEN) ? MAX_GREEN : mElapsed[m] + 1;
        mElapsed[m] = e;
        if (dem != 0 && ((e >= MIN_GREEN && !t[0]) || e >= MAX_GREEN)) begin
          mNext[m] = scanNext(mActive[m], dem);
          mState[m] = 1;
          mPhase[m] = YELLOW_T;
        end
      end else if (mState[m] == 1) begin
        if (mPhase[m] == 1) begin
          if (allredT[m] == 0) grant = 1;
          else begin
            mState[m] = 2;
            mPhase[m] = allredT[m];
          end
        end else mPhase[m] = mPhase[m] - 1;
      end else begin
        if (mPhase[m] == 1) grant = 1;
        else mPhase[m] = mPhase[m] - 1;
      end
    end
    if (grant) begin
      mActive[m] = mNext[m];
      mElapsed[m] = 0;
      mState[m] = 0;
      dem = dem & ~(4'b0001 << mNext[m]);
    end
    mDemand[m] = dem;
  endtask

  function automatic exp_t modelOut(input int m);
    exp_t r;
    for (int i = 0; i < N_DIR; i++) begin
      if (mState[m] != 2 && mActive[m] == i)
        r.led[3*i +: 3] = (mState[m] == 0) ? 3'b001 : 3'b010;
      else
        r.led[3*i +: 3] = 3'b100;
    end
    r.act = 3'(mActive[m]);
    if (mState[m] == 0)
      r.cnt = (mElapsed[m] >= MIN_GREEN) ? 8'd0 : 8'(MIN_GREEN - mElapsed[m]);
    else
      r.cnt = 8'(mPhase[m]);
    r.tick = (mPresc[m] == CNT_MAX - 1);
    return r;
  endfunction

  function automatic bit ledLegal(input logic [11:0] led);
    int nonRed;
    logic [2:0] f;
    nonRed = 0;
    for (int i = 0; i < N_DIR; i++) begin
      f = led[3*i +: 3];
      if (f != 3'b001 && f != 3'b010 && f != 3'b100) return 0;
      if (f != 3'b100) nonRed++;
    end
    return (nonRed <= 1);
  endfunction

  function automatic bit anyYellow(input logic [11:0] led);
    for (int i = 0; i < N_DIR; i++)
      if (led[3*i +: 3] == 3'b010) return 1;
    return 0;
  endfunction

  task automatic applyStimulus(input logic [3:0] sw, input logic key);
    exp_t e;
    @(negedge CLOCK_50);
    SW = sw;
    KEY = key;
    modelStep(0, sw, key);
    modelStep(1, sw, key);
    sbQ.push_back(modelOut(0));
    sbQ.push_back(modelOut(1));
    @(posedge CLOCK_50);
    #1;
    if (sbQ.size() < 2) checkOutput("scoreboardDepth", sbQ.size(), 2);
    else begin
      e = sbQ.pop_front();
      checkOutput("ledA", ledA, e.led);
      checkOutput("activeA", actA, e.act);
      checkOutput("cntA", cntA, e.cnt);
      checkOutput("tickA", tickA, e.tick);
      e = sbQ.pop_front();
      checkOutput("ledB", ledB, e.led);
      checkOutput("activeB", actB, e.act);
      checkOutput("cntB", cntB, e.cnt);
      checkOutput("tickB", tickB, e.tick);
    end
    checkOutput("ledLegalA", ledLegal(ledA), 1);
    checkOutput("ledLegalB", ledLegal(ledB), 1);
    k++;
  endtask

  task automatic doReset();
    repeat (3) applyStimulus(4'b0, 1'b1);
    k = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lastTick;
    int yA, arA, gA, yB, arB, gB;
    int gStart, prevAct;
    bit prevYel, yel, found;
    int grants[$];

    // Idle: approach 0 holds green, countdown drains to 0, 5-cycle tick period
    doReset();
    checkOutput("rstLed", ledA, RST_LED);
    checkOutput("rstActive", actA, 0);
    checkOutput("rstCnt", cntA, MIN_GREEN);
    checkOutput("rstTick", tickA, 0);
    lastTick = -1;
    for (int s = 0; s < 200; s++) begin
      applyStimulus(4'b0, 1'b0);
      if (tickA) begin
        if (lastTick >= 0) checkOutput("tickPeriod", k - lastTick, 5);
        lastTick = k;
      end
    end
    checkOutput("idleLed", ledA, RST_LED);
    checkOutput("idleActive", actA, 0);
    checkOutput("idleCnt", cntA, 0);

    // Single pulse on approach 2
    doReset();
    yA = -1; arA = -1; gA = -1; yB = -1; arB = -1; gB = -1;
    for (int s = 0; s < 100; s++) begin
      applyStimulus((k == 9) ? 4'b0100 : 4'b0000, 1'b0);
      if (yA < 0 && ledA[2:0] == 3'b010) yA = k;
      if (arA < 0 && ledA == ALL_RED) arA = k;
      if (gA < 0 && actA == 3'd2) gA = k;
      if (yB < 0 && ledB[2:0] == 3'b010) yB = k;
      if (arB < 0 && ledB == ALL_RED) arB = k;
      if (gB < 0 && actB == 3'd2) gB = k;
    end
    checkOutput("pulseYellowA", yA, 20);
    checkOutput("pulseAllRedA", arA, 30);
    checkOutput("pulseGrantA", gA, 35);
    checkOutput("pulseLedA", ledA, 12'b100_001_100_100);
    checkOutput("pulseYellowB", yB, 20);
    checkOutput("pulseGrantB", gB, 30);
    checkOutput("noAllRedB", arB, 32'hffff_ffff);
    checkOutput("pulseLedB", ledB, 12'b100_001_100_100);

    // Served approach busy: green runs to the cap
    doReset();
    yA = -1; yB = -1;
    for (int s = 0; s < 100; s++) begin
      applyStimulus(4'b0001 | ((k == 2) ? 4'b0010 : 4'b0000), 1'b0);
      if (k == 25) checkOutput("extendedA", ledA[2:0], 3'b001);
      if (yA < 0 && ledA[2:0] == 3'b010) yA = k;
      if (yB < 0 && ledB[2:0] == 3'b010) yB = k;
    end
    checkOutput("maxGreenYellowA", yA, 40);
    checkOutput("maxGreenYellowB", yB, 40);

    // All approaches busy: full rotation
    doReset();
    gStart = 0; prevAct = 0; prevYel = 0;
    for (int s = 0; s < 400 && grants.size() < 4; s++) begin
      applyStimulus(4'b1111, 1'b0);
      if (int'(actA) != prevAct) begin
        grants.push_back(int'(actA));
        gStart = k;
        prevAct = int'(actA);
      end
      yel = anyYellow(ledA);
      if (yel && !prevYel) checkOutput("greenLen", k - gStart, 40);
      prevYel = yel;
    end
    checkOutput("grantCount", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      checkOutput("grantOrder", grants[i], (i + 1) % N_DIR);

    // Reset during yellow
    found = 0;
    for (int s = 0; s < 200 && !found; s++) begin
      applyStimulus(4'b1111, 1'b0);
      if (anyYellow(ledA)) found = 1;
    end
    if (!found) checkOutput("reachYellow", 0, 1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("midRstLed", ledA, RST_LED);
    checkOutput("midRstActive", actA, 0);
    checkOutput("midRstCnt", cntA, MIN_GREEN);
    checkOutput("midRstTick", tickA, 0);
    k = 0;
    for (int s = 0; s < 80; s++) applyStimulus(4'b0000, 1'b0);
    checkOutput("demandClearedActive", actA, 0);
    checkOutput("demandClearedLed", ledA, RST_LED);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
